// File: rtl/seq_cmd_if.sv
// Command stream handshake between a command source and seq_cmd_sequencer.
// The master drives valid/op/arg; the slave returns ready.
interface seq_cmd_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/seq_cmd_sequencer.sv
// Command FIFO plus IDLE/RUN/HOLD sequencer that drives the en strobe and d data.
// Define SEQ_CMD_SEQUENCER_STATS_EN to add the saturating inc_total en-cycle counter.
module seq_cmd_sequencer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    seq_cmd_if.slave         cmd,
    output logic             en,
    output logic [WIDTH-1:0] d,
`ifdef SEQ_CMD_SEQUENCER_STATS_EN
    output logic [15:0]      inc_total,
`endif
    output logic             busy
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [1:0] OpNop  = 2'd0;
    localparam logic [1:0] OpInc  = 2'd1;
    localparam logic [1:0] OpLoad = 2'd2;
    localparam logic [1:0] OpWait = 2'd3;

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

    logic [WIDTH+1:0] mem [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             full, empty, push, pop;
    logic [1:0]       head_op;
    logic [WIDTH-1:0] head_arg;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] d_q, d_d;

    assign full          = (count_q == CntW'(FIFO_DEPTH));
    assign empty         = (count_q == '0);
    assign cmd.cmd_ready = !full && !rst;
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign head_op       = mem[rd_ptr_q][WIDTH+1:WIDTH];
    assign head_arg      = mem[rd_ptr_q][WIDTH-1:0];
    // Pop while idle, or on the last cycle of a segment so commands run without bubbles.
    assign pop           = !empty && (state_q == StIdle || rem_q == WIDTH'(1));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {cmd.cmd_op, cmd.cmd_arg};
    end

    // Pointers are PtrW bits wide, so they wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_q <= count_q + CntW'(1);
            else if (pop && !push) count_q <= count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            d_q     <= d_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        d_d     = d_q;
        if (state_q != StIdle) begin
            rem_d = rem_q - WIDTH'(1);
            if (rem_q == WIDTH'(1)) state_d = StIdle;
        end
        if (pop) begin
            unique case (head_op)
                OpNop: state_d = StIdle;
                OpInc: begin
                    if (head_arg != '0) begin
                        state_d = StRun;
                        rem_d   = head_arg;
                    end else begin
                        state_d = StIdle;
                    end
                end
                OpLoad: begin
                    d_d     = head_arg;
                    state_d = StHold;
                    rem_d   = WIDTH'(1);
                end
                OpWait: begin
                    state_d = StHold;
                    rem_d   = (head_arg == '0) ? WIDTH'(1) : head_arg;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        en   = (state_q == StRun);
        d    = d_q;
        busy = (state_q != StIdle) || !empty;
    end

`ifdef SEQ_CMD_SEQUENCER_STATS_EN
    logic [15:0] inc_total_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_total_q <= '0;
        end else if (en && inc_total_q != 16'hFFFF) begin
            inc_total_q <= inc_total_q + 16'd1;
        end
    end

    assign inc_total = inc_total_q;
`endif
endmodule
